// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES-128 inverse key schedule:
//   AES_NR   number of rounds (10, eleven round keys)
//   word_t   32-bit key-schedule word
//   state_t  key-schedule FSM states (IDLE / FWD / EMIT)
//   rcon()   round constant Rcon[r] for r = 1..10 (0 elsewhere)
// The FWD state is only reachable when AES_INV_KEY_FWD_EN is defined.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam logic [3:0] LAST_RND = 4'(AES_NR);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational 8-bit forward AES S-box.
//   a  in  8  input byte
//   y  out 8  S-box(a)
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the top byte; entry a is found at bit offset (255-a)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule
// Emits the eleven AES-128 round keys last-first (round 10 down to 0) for
// the decryption datapath, running the key expansion backwards one round
// per valid/ready handshake.
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-low reset
//   key_in     in   128  round-10 key (cipher key with AES_INV_KEY_FWD_EN)
//   start      in   1    load request, honoured only while idle
//   idle       out  1    ready to accept start
//   round_key  out  128  current round key, byte 0 at [127:120]
//   round_idx  out  4    round number of round_key
//   key_valid  out  1    round_key/round_idx valid
//   key_ready  in   1    consumer accepts on key_valid & key_ready
//   done       out  1    one-cycle pulse after round 0 is accepted
// Optional build macro AES_INV_KEY_FWD_EN: key_in is the cipher key and a
// 10-cycle forward expansion precedes the emission.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; idle=1
// ST_FWD  | forward-expanding cipher key to round 10 (FWD build only)
// ST_EMIT | presenting round_key; step backwards on each handshake
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         idle,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         done
);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  word_t w0, w1, w2, w3;
  word_t inv_w0, inv_w1, inv_w2, inv_w3;
  word_t sub_src, rot_word, sub_word;
  logic [3:0] rc_idx;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign inv_w3 = w3 ^ w2;
  assign inv_w2 = w2 ^ w1;
  assign inv_w1 = w1 ^ w0;

  // One SubWord datapath serves both directions: the inverse step needs
  // the recovered w3 of the previous round, the forward step the current w3.
`ifdef AES_INV_KEY_FWD_EN
  word_t fwd_w0, fwd_w1, fwd_w2, fwd_w3;
  assign sub_src = (state_q == ST_FWD) ? w3 : inv_w3;
  assign rc_idx  = (state_q == ST_FWD) ? idx_q + 4'd1 : idx_q;
`else
  assign sub_src = inv_w3;
  assign rc_idx  = idx_q;
`endif

  assign rot_word = {sub_src[23:0], sub_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_word[8*i +: 8]),
      .y (sub_word[8*i +: 8])
    );
  end

  assign inv_w0 = w0 ^ sub_word ^ {rcon(rc_idx), 24'h0};

`ifdef AES_INV_KEY_FWD_EN
  assign fwd_w0 = inv_w0;
  assign fwd_w1 = w1 ^ fwd_w0;
  assign fwd_w2 = w2 ^ fwd_w1;
  assign fwd_w3 = w3 ^ fwd_w2;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d = key_in;
`ifdef AES_INV_KEY_FWD_EN
          idx_d   = 4'd0;
          state_d = ST_FWD;
`else
          idx_d   = LAST_RND;
          state_d = ST_EMIT;
`endif
        end
      end
`ifdef AES_INV_KEY_FWD_EN
      ST_FWD: begin
        key_d = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_RND - 4'd1) state_d = ST_EMIT;
      end
`endif
      ST_EMIT: begin
        if (key_ready) begin
          if (idx_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = {inv_w0, inv_w1, inv_w2, inv_w3};
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign idle      = (state_q == ST_IDLE);
  assign key_valid = (state_q == ST_EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule
// Scoreboard bench for aes_inv_key_schedule using the FIPS-197 A.1 key
// expansion as reference. Expected {round, key} pairs are queued when start
// is driven and popped on every observed handshake.
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         start;
  logic         idle;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         done;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .start     (start),
    .idle      (idle),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rk [0:10];
  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [131:0] exp_q[$];
  logic         mon_en;
  logic         prev_stall;
  logic         prev_hs_zero;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  logic [131:0] e;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall   = 1'b0;
      prev_hs_zero = 1'b0;
    end else begin
      chk("done", {127'h0, done}, {127'h0, prev_hs_zero});
      if (prev_hs_zero) chk("idle_in_done", {127'h0, idle}, 128'h1);
      if (prev_stall) begin
        chk("stall_key", round_key, prev_key);
        chk("stall_idx", {124'h0, round_idx}, {124'h0, prev_idx});
        chk("stall_valid", {127'h0, key_valid}, 128'h1);
      end
      prev_stall   = 1'b0;
      prev_hs_zero = 1'b0;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_key", {127'h0, key_valid}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("key", round_key, e[127:0]);
          chk("idx", {124'h0, round_idx}, {124'h0, e[131:128]});
        end
        prev_hs_zero = (round_idx == 4'd0);
      end else if (key_valid) begin
        prev_stall = 1'b1;
        prev_key   = round_key;
        prev_idx   = round_idx;
      end
    end
  end

  logic [127:0] load_key;

  task automatic push_expected();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
  endtask

  // Drives start (expects idle), then consumes keys until the scoreboard is
  // drained and done is seen. mode 0: ready high, 1: random ready,
  // 2: ready high plus a stray start with a different key mid-sequence.
  task automatic run_seq(input int mode);
    int cyc;
    key_in = load_key;
    start  = 1'b1;
    push_expected();
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_KEY_FWD_EN
    for (int i = 0; i < 10; i++) begin
      chk("fwd_idle", {127'h0, idle}, 128'h0);
      chk("fwd_valid", {127'h0, key_valid}, 128'h0);
      @(posedge clk); #1;
    end
`endif
    chk("first_valid", {127'h0, key_valid}, 128'h1);
    chk("first_idx", {124'h0, round_idx}, 128'd10);
    cyc = 0;
    while (!(exp_q.size() == 0 && done)) begin
      key_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && (cyc == 3 || cyc == 4)) begin
        start  = 1'b1;
        key_in = ~load_key;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 300) begin
        chk("timeout", 128'(cyc), 128'h0);
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int guard;
`ifdef AES_INV_KEY_FWD_EN
    load_key = rk[0];
`else
    load_key = rk[10];
`endif
    mon_en    = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    key_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", {127'h0, idle}, 128'h1);
    chk("rst_valid", {127'h0, key_valid}, 128'h0);
    chk("rst_done", {127'h0, done}, 128'h0);
    chk("rst_key", round_key, 128'h0);
    chk("rst_idx", {124'h0, round_idx}, 128'h0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // key_ready without valid must not move anything
    key_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_idle", {127'h0, idle}, 128'h1);
    chk("ready_in_idle_idx", {124'h0, round_idx}, 128'h0);

    run_seq(0);
    @(posedge clk); #1;
    run_seq(1);
    @(posedge clk); #1;
    run_seq(2);
    @(posedge clk); #1;

    // reset after the round-6 handshake
    key_ready = 1'b1;
    key_in    = load_key;
    start     = 1'b1;
    push_expected();
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(key_valid && round_idx == 4'd5) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_round5", {124'h0, round_idx}, 128'd5);
    mon_en = 1'b0;
    exp_q.delete();
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", {127'h0, key_valid}, 128'h0);
    chk("async_done", {127'h0, done}, 128'h0);
    chk("async_key", round_key, 128'h0);
    chk("async_idx", {124'h0, round_idx}, 128'h0);
    chk("async_idle", {127'h0, idle}, 128'h1);
    @(posedge clk); #1;
    chk("held_done", {127'h0, done}, 128'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_seq(0);

    // restart in the done cycle
    chk("done_cycle", {127'h0, done}, 128'h1);
    run_seq(0);
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", {127'h0, idle}, 128'h1);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
